// File: rtl/bgpu_pkg.sv
// Shared GPU core types: instruction encoding and warp-id width helpers.
package bgpu_pkg;

  typedef struct packed {
    logic [3:0] eu_sel;
    logic [7:0] opcode;
  } inst_t;

  function automatic int unsigned warp_id_width(int unsigned num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  localparam int unsigned DefaultNumWarps   = 8;
  localparam int unsigned DefaultWarpIdWidth = warp_id_width(DefaultNumWarps);

  typedef logic [DefaultWarpIdWidth-1:0] warp_id_t;

endpackage

// File: rtl/dispatch_arbiter_rr_grant.sv
// Round-robin one-hot grant with a registered rotating priority pointer.
module rr_grant #(
  parameter int unsigned NumReq = 8,
  localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumReq-1:0]   req_i,
  input  logic                en_i,
  output logic [NumReq-1:0]   grant_o,
  output logic [IdxWidth-1:0] grant_idx_o
);

  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic [IdxWidth-1:0] cand_idx;
  int unsigned         cand;
  logic                found;

  // Scan from the pointer upward, wrapping modulo NumReq; first request wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      cand_idx = IdxWidth'(cand);
      if (en_i && !found && req_i[cand_idx]) begin
        found             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        grant_idx_o       = cand_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (grant_idx_o == IdxWidth'(NumReq - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dispatch_arbiter.sv
// Picks one ready warp per cycle into a one-entry output stage and routes
// writebacks / operand-read handshakes back to the owning warp dispatcher.
module dispatch_arbiter
  import bgpu_pkg::*;
#(
  parameter int unsigned NumWarps        = 8,
  parameter int unsigned NumTags         = 8,
  parameter int unsigned PcWidth         = 32,
  parameter int unsigned WarpWidth       = 32,
  parameter int unsigned RegIdxWidth     = 6,
  parameter int unsigned OperandsPerInst = 2,
  parameter int unsigned DispatchWidth   = 1,
  parameter int unsigned WritebackWidth  = 1,
  localparam int unsigned WarpIdWidth    = warp_id_width(NumWarps),
  localparam int unsigned TagWidth       = $clog2(NumTags),
  localparam int unsigned OpsWidth       = OperandsPerInst * RegIdxWidth
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumWarps-1:0]                   disp_valid_i,
  output logic [NumWarps-1:0]                   disp_ready_o,
  input  logic [NumWarps*TagWidth-1:0]          disp_tag_i,
  input  logic [NumWarps*PcWidth-1:0]           disp_pc_i,
  input  logic [NumWarps*WarpWidth-1:0]         disp_act_mask_i,
  input  inst_t [NumWarps-1:0]                  disp_inst_i,
  input  logic [NumWarps*RegIdxWidth-1:0]       disp_dst_i,
  input  logic [NumWarps*OperandsPerInst-1:0]   disp_operands_is_reg_i,
  input  logic [NumWarps*OpsWidth-1:0]          disp_operands_i,
  input  logic                                  opc_ready_i,
  output logic                                  arb_valid_o,
  output logic [WarpIdWidth-1:0]                arb_warp_id_o,
  output logic [TagWidth-1:0]                   arb_tag_o,
  output logic [PcWidth-1:0]                    arb_pc_o,
  output logic [WarpWidth-1:0]                  arb_act_mask_o,
  output inst_t                                 arb_inst_o,
  output logic [RegIdxWidth-1:0]                arb_dst_o,
  output logic [OperandsPerInst-1:0]            arb_operands_is_reg_o,
  output logic [OpsWidth-1:0]                   arb_operands_o,
  input  logic [DispatchWidth-1:0]              opc_eu_handshake_i,
  input  logic [DispatchWidth*WarpIdWidth-1:0]  opc_eu_warp_id_i,
  input  logic [DispatchWidth*TagWidth-1:0]     opc_eu_tag_i,
  output logic [NumWarps*DispatchWidth-1:0]     disp_opc_eu_handshake_o,
  output logic [DispatchWidth*TagWidth-1:0]     disp_opc_eu_tag_o,
  input  logic [WritebackWidth-1:0]             eu_valid_i,
  input  logic [WritebackWidth*WarpIdWidth-1:0] eu_warp_id_i,
  input  logic [WritebackWidth*TagWidth-1:0]    eu_tag_i,
  output logic [NumWarps*WritebackWidth-1:0]    disp_eu_valid_o,
  output logic [WritebackWidth*TagWidth-1:0]    disp_eu_tag_o
);

  logic                       load;
  logic [NumWarps-1:0]        grant;
  logic [WarpIdWidth-1:0]     grant_idx;

  logic                       valid_q, valid_d;
  logic [WarpIdWidth-1:0]     warp_id_q, warp_id_d;
  logic [TagWidth-1:0]        tag_q, tag_d;
  logic [PcWidth-1:0]         pc_q, pc_d;
  logic [WarpWidth-1:0]       mask_q, mask_d;
  inst_t                      inst_q, inst_d;
  logic [RegIdxWidth-1:0]     dst_q, dst_d;
  logic [OperandsPerInst-1:0] is_reg_q, is_reg_d;
  logic [OpsWidth-1:0]        ops_q, ops_d;

  assign load = ~valid_q | opc_ready_i;

  // Gating with rst_ni keeps grants silent while reset is asserted.
  rr_grant #(
    .NumReq (NumWarps)
  ) u_rr_grant (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (disp_valid_i),
    .en_i        (load & rst_ni),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign disp_ready_o = grant;

  always_comb begin
    valid_d   = valid_q;
    warp_id_d = warp_id_q;
    tag_d     = tag_q;
    pc_d      = pc_q;
    mask_d    = mask_q;
    inst_d    = inst_q;
    dst_d     = dst_q;
    is_reg_d  = is_reg_q;
    ops_d     = ops_q;
    if (load) begin
      valid_d = |grant;
      if (|grant) begin
        warp_id_d = grant_idx;
        tag_d     = disp_tag_i[grant_idx*TagWidth +: TagWidth];
        pc_d      = disp_pc_i[grant_idx*PcWidth +: PcWidth];
        mask_d    = disp_act_mask_i[grant_idx*WarpWidth +: WarpWidth];
        inst_d    = disp_inst_i[grant_idx];
        dst_d     = disp_dst_i[grant_idx*RegIdxWidth +: RegIdxWidth];
        is_reg_d  = disp_operands_is_reg_i[grant_idx*OperandsPerInst +: OperandsPerInst];
        ops_d     = disp_operands_i[grant_idx*OpsWidth +: OpsWidth];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      warp_id_q <= '0;
      tag_q     <= '0;
      pc_q      <= '0;
      mask_q    <= '0;
      inst_q    <= '0;
      dst_q     <= '0;
      is_reg_q  <= '0;
      ops_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      warp_id_q <= warp_id_d;
      tag_q     <= tag_d;
      pc_q      <= pc_d;
      mask_q    <= mask_d;
      inst_q    <= inst_d;
      dst_q     <= dst_d;
      is_reg_q  <= is_reg_d;
      ops_q     <= ops_d;
    end
  end

  assign arb_valid_o           = valid_q;
  assign arb_warp_id_o         = warp_id_q;
  assign arb_tag_o             = tag_q;
  assign arb_pc_o              = pc_q;
  assign arb_act_mask_o        = mask_q;
  assign arb_inst_o            = inst_q;
  assign arb_dst_o             = dst_q;
  assign arb_operands_is_reg_o = is_reg_q;
  assign arb_operands_o        = ops_q;

  // Return-path demux: bit [w*Width + i] is lane i addressed to warp w.
  always_comb begin
    disp_eu_valid_o         = '0;
    disp_opc_eu_handshake_o = '0;
    for (int unsigned w = 0; w < NumWarps; w++) begin
      for (int unsigned i = 0; i < WritebackWidth; i++) begin
        disp_eu_valid_o[w*WritebackWidth+i] = eu_valid_i[i] &&
            (eu_warp_id_i[i*WarpIdWidth +: WarpIdWidth] == WarpIdWidth'(w));
      end
      for (int unsigned i = 0; i < DispatchWidth; i++) begin
        disp_opc_eu_handshake_o[w*DispatchWidth+i] = opc_eu_handshake_i[i] &&
            (opc_eu_warp_id_i[i*WarpIdWidth +: WarpIdWidth] == WarpIdWidth'(w));
      end
    end
  end

  assign disp_eu_tag_o     = eu_tag_i;
  assign disp_opc_eu_tag_o = opc_eu_tag_i;

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Bench for dispatch_arbiter: vector table, directed corner sequences and a
// randomized run against a queue-free behavioural model of the arbiter.
module tb_dispatch_arbiter;
  import bgpu_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    valid_v;
  logic [N-1:0]    ready_o;
  logic [N*3-1:0]  tag_f;
  logic [N*32-1:0] pc_f;
  logic [N*32-1:0] mask_f;
  inst_t [N-1:0]   inst_f;
  logic [N*6-1:0]  dst_f;
  logic [N*2-1:0]  isreg_f;
  logic [N*12-1:0] ops_f;
  logic            opc_ready;
  logic            arb_valid;
  logic [2:0]      arb_id, arb_tag;
  logic [31:0]     arb_pc, arb_mask;
  inst_t           arb_inst;
  logic [5:0]      arb_dst;
  logic [1:0]      arb_isreg;
  logic [11:0]     arb_ops;
  logic            hs_i;
  logic [2:0]      hs_wid, hs_tag;
  logic [N-1:0]    hs_o;
  logic [2:0]      hs_tag_o;
  logic            eu_v;
  logic [2:0]      eu_wid, eu_tag;
  logic [N-1:0]    eu_o;
  logic [2:0]      eu_tag_o;

  logic [2:0]  tag_a  [N];
  logic [31:0] pc_a   [N];
  logic [31:0] mask_a [N];
  inst_t       inst_a [N];
  logic [5:0]  dst_a  [N];
  logic [1:0]  isreg_a[N];
  logic [11:0] ops_a  [N];

  always_comb begin
    for (int w = 0; w < N; w++) begin
      tag_f[w*3 +: 3]     = tag_a[w];
      pc_f[w*32 +: 32]    = pc_a[w];
      mask_f[w*32 +: 32]  = mask_a[w];
      inst_f[w]           = inst_a[w];
      dst_f[w*6 +: 6]     = dst_a[w];
      isreg_f[w*2 +: 2]   = isreg_a[w];
      ops_f[w*12 +: 12]   = ops_a[w];
    end
  end

  dispatch_arbiter u_dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .disp_valid_i            (valid_v),
    .disp_ready_o            (ready_o),
    .disp_tag_i              (tag_f),
    .disp_pc_i               (pc_f),
    .disp_act_mask_i         (mask_f),
    .disp_inst_i             (inst_f),
    .disp_dst_i              (dst_f),
    .disp_operands_is_reg_i  (isreg_f),
    .disp_operands_i         (ops_f),
    .opc_ready_i             (opc_ready),
    .arb_valid_o             (arb_valid),
    .arb_warp_id_o           (arb_id),
    .arb_tag_o               (arb_tag),
    .arb_pc_o                (arb_pc),
    .arb_act_mask_o          (arb_mask),
    .arb_inst_o              (arb_inst),
    .arb_dst_o               (arb_dst),
    .arb_operands_is_reg_o   (arb_isreg),
    .arb_operands_o          (arb_ops),
    .opc_eu_handshake_i      (hs_i),
    .opc_eu_warp_id_i        (hs_wid),
    .opc_eu_tag_i            (hs_tag),
    .disp_opc_eu_handshake_o (hs_o),
    .disp_opc_eu_tag_o       (hs_tag_o),
    .eu_valid_i              (eu_v),
    .eu_warp_id_i            (eu_wid),
    .eu_tag_i                (eu_tag),
    .disp_eu_valid_o         (eu_o),
    .disp_eu_tag_o           (eu_tag_o)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Behavioural model: the held instruction and the next warp to be favoured.
  bit          m_valid;
  int          m_ptr;
  int          m_warp;
  logic [2:0]  m_tag;
  logic [31:0] m_pc;
  logic [63:0] m_pl;

  function automatic logic [63:0] dut_payload();
    return {arb_mask, arb_inst, arb_dst, arb_isreg, arb_ops};
  endfunction

  // Checks the current cycle against the model, then advances one clock.
  task automatic tick();
    bit          load;
    int          gw;
    logic [N-1:0] exp_rdy, exp_eu, exp_hs;
    #2;
    load = !m_valid || opc_ready;
    gw = -1;
    if (load) begin
      for (int k = 0; k < N; k++) begin
        int w;
        w = (m_ptr + k) % N;
        if (gw < 0 && valid_v[w]) gw = w;
      end
    end
    exp_rdy = '0;
    if (gw >= 0) exp_rdy[gw] = 1'b1;
    for (int w = 0; w < N; w++) begin
      exp_eu[w] = eu_v && (int'(eu_wid) == w);
      exp_hs[w] = hs_i && (int'(hs_wid) == w);
    end
    check("disp_ready", 64'(ready_o), 64'(exp_rdy));
    check("arb_valid", 64'(arb_valid), 64'(m_valid));
    if (m_valid) begin
      check("arb_warp_id", 64'(arb_id), 64'(m_warp));
      check("arb_pc", 64'(arb_pc), 64'(m_pc));
      check("arb_tag", 64'(arb_tag), 64'(m_tag));
      check("arb_payload", dut_payload(), m_pl);
    end
    check("eu_route", 64'(eu_o), 64'(exp_eu));
    check("eu_tag", 64'(eu_tag_o), 64'(eu_tag));
    check("hs_route", 64'(hs_o), 64'(exp_hs));
    check("hs_tag", 64'(hs_tag_o), 64'(hs_tag));
    if (load) begin
      if (gw >= 0) begin
        m_valid = 1'b1;
        m_warp  = gw;
        m_ptr   = (gw + 1) % N;
        m_tag   = tag_a[gw];
        m_pc    = pc_a[gw];
        m_pl    = {mask_a[gw], inst_a[gw], dst_a[gw], isreg_a[gw], ops_a[gw]};
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic         rdy;
    logic [N-1:0] exp_rdy;
    logic         exp_av;
    int           exp_id;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{8'h04, 1'b1, 8'h04, 1'b1, 2};
    tbl[1] = '{8'hFF, 1'b1, 8'h08, 1'b1, 3};
    tbl[2] = '{8'h03, 1'b0, 8'h00, 1'b1, 3};
    tbl[3] = '{8'h03, 1'b1, 8'h01, 1'b1, 0};
    tbl[4] = '{8'h00, 1'b1, 8'h00, 1'b0, 0};
    tbl[5] = '{8'h00, 1'b0, 8'h00, 1'b0, 0};
    tbl[6] = '{8'h81, 1'b0, 8'h80, 1'b1, 7};
    tbl[7] = '{8'h81, 1'b1, 8'h01, 1'b1, 0};
    tbl[8] = '{8'hF0, 1'b1, 8'h10, 1'b1, 4};

    for (int w = 0; w < N; w++) begin
      tag_a[w]   = 3'(w);
      pc_a[w]    = 32'h1000 + 32'(w);
      mask_a[w]  = 32'hFFFF_0000 | 32'(w);
      inst_a[w]  = inst_t'(12'h100 + 12'(w));
      dst_a[w]   = 6'(w + 10);
      isreg_a[w] = 2'(w);
      ops_a[w]   = 12'(w * 65);
    end
    hs_i = 1'b0; hs_wid = '0; hs_tag = '0;
    eu_v = 1'b0; eu_wid = '0; eu_tag = '0;
    m_valid = 1'b0; m_ptr = 0; m_warp = 0; m_tag = '0; m_pc = '0; m_pl = '0;

    // Reset state, with every warp requesting.
    rst_n = 1'b0;
    valid_v = 8'hFF;
    opc_ready = 1'b1;
    #1;
    check("reset_ready", 64'(ready_o), 64'h0);
    check("reset_valid", 64'(arb_valid), 64'h0);
    check("reset_pc", 64'(arb_pc), 64'h0);
    check("reset_id", 64'(arb_id), 64'h0);
    check("reset_payload", dut_payload(), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      valid_v   = tbl[i].valid;
      opc_ready = tbl[i].rdy;
      #2;
      check($sformatf("tbl%0d_ready", i), 64'(ready_o), 64'(tbl[i].exp_rdy));
      tick();
      check($sformatf("tbl%0d_valid", i), 64'(arb_valid), 64'(tbl[i].exp_av));
      if (tbl[i].exp_av) begin
        check($sformatf("tbl%0d_id", i), 64'(arb_id), 64'(tbl[i].exp_id));
        check($sformatf("tbl%0d_pc", i), 64'(arb_pc), 64'h1000 + 64'(tbl[i].exp_id));
      end
    end

    // Backpressure: warp 4 held, inputs of warp 4 change underneath.
    valid_v   = 8'hFF;
    opc_ready = 1'b0;
    pc_a[4]   = 32'hDEAD_0004;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("stall_ready", 64'(ready_o), 64'h0);
      check("stall_id", 64'(arb_id), 64'd4);
      check("stall_pc", 64'(arb_pc), 64'h1004);
      tick();
    end
    opc_ready = 1'b1;
    #2;
    check("post_stall_ready", 64'(ready_o), 64'h20);
    tick();
    check("post_stall_id", 64'(arb_id), 64'd5);
    pc_a[4] = 32'h1004;

    // Reset while an instruction is held under backpressure.
    opc_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(arb_valid), 64'h0);
    check("midrst_ready", 64'(ready_o), 64'h0);
    m_valid = 1'b0;
    m_ptr   = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full throughput round robin from pointer 0.
    opc_ready = 1'b1;
    valid_v   = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      #2;
      check($sformatf("rr%0d_ready", i), 64'(ready_o), 64'(1) << (i % N));
      tick();
      check($sformatf("rr%0d_id", i), 64'(arb_id), 64'(i % N));
    end

    // Return-path demux, directed.
    valid_v = '0;
    eu_v = 1'b1; eu_wid = 3'd5; eu_tag = 3'd3;
    hs_i = 1'b1; hs_wid = 3'd0; hs_tag = 3'd6;
    #1;
    check("eu_w5", 64'(eu_o), 64'h20);
    check("eu_tag3", 64'(eu_tag_o), 64'd3);
    check("hs_w0", 64'(hs_o), 64'h01);
    check("hs_tag6", 64'(hs_tag_o), 64'd6);
    tick();

    // Randomized run against the model.
    for (int c = 0; c < 400; c++) begin
      valid_v   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) valid_v = '0;
      opc_ready = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < N; w++) begin
        tag_a[w]   = 3'($urandom);
        pc_a[w]    = $urandom;
        mask_a[w]  = $urandom;
        inst_a[w]  = inst_t'(12'($urandom));
        dst_a[w]   = 6'($urandom);
        isreg_a[w] = 2'($urandom);
        ops_a[w]   = 12'($urandom);
      end
      eu_v   = 1'($urandom);
      eu_wid = 3'($urandom);
      eu_tag = 3'($urandom);
      hs_i   = 1'($urandom);
      hs_wid = 3'($urandom);
      hs_tag = 3'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
